// File: rtl/rsa_mmm.sv
// Bit-serial Montgomery multiplier: P = A*B*2^-WIDTH mod M, one bit of A per
// enabled cycle. Ports: clk, rst (sync, active high), ena (clock enable),
// clear (active low, keeps P), ld_a (start), ld_r (capture result),
// A/B/M operands, P result register, done (WIDTH iterations complete).
// Optional macro RSA_MMM_FINAL_SUB_EN adds the final conditional subtract.
module rsa_mmm #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             clear,
  input  logic             ld_a,
  input  logic             ld_r,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] M,
  output logic [WIDTH-1:0] P,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
`ifdef RSA_MMM_FINAL_SUB_EN
  localparam int AW = WIDTH + 2;
`else
  localparam int AW = WIDTH + 1;
`endif

  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic             done_q, done_d;

  logic [AW-1:0]    s, t;
  logic [WIDTH-1:0] red;

  // One Montgomery step: add B if the scanned bit is set, then add M
  // if needed to make the sum even, so the halving is exact.
  always_comb begin
    s = acc_q + (a_sr_q[0] ? AW'(B) : '0);
    t = s + (s[0] ? AW'(M) : '0);
  end

`ifdef RSA_MMM_FINAL_SUB_EN
  always_comb begin
    red = acc_q[WIDTH-1:0];
    if (acc_q >= AW'(M)) red = WIDTH'(acc_q - AW'(M));
  end
`else
  // acc < 2M < 2^WIDTH here, so plain truncation loses nothing.
  assign red = acc_q[WIDTH-1:0];
`endif

  always_comb begin
    a_sr_d = a_sr_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    done_d = done_q;
    p_d    = p_q;
    if (ena) begin
      // Result capture sees the pre-edge accumulator, independent of
      // whatever the run logic does on this same edge.
      if (ld_r) p_d = red;
      if (!clear) begin
        a_sr_d = '0;
        acc_d  = '0;
        cnt_d  = '0;
        done_d = 1'b0;
      end else if (ld_a) begin
        a_sr_d = A;
        acc_d  = '0;
        cnt_d  = '0;
        done_d = 1'b0;
      end else if (cnt_q < CW'(WIDTH)) begin
        a_sr_d = a_sr_q >> 1;
        acc_d  = t >> 1;
        cnt_d  = cnt_q + CW'(1);
        done_d = (cnt_q == CW'(WIDTH - 1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr_q <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      p_q    <= '0;
      done_q <= 1'b0;
    end else begin
      a_sr_q <= a_sr_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      p_q    <= p_d;
      done_q <= done_d;
    end
  end

  assign P    = p_q;
  assign done = done_q;

endmodule

// File: doc/rsa_mmm.md
# rsa_mmm

Bit-serial Montgomery modular multiplier: the datapath stage directly downstream of the RSA control FSM, driven by that FSM's `clear_mmm`, `ld_a` and `ld_r` strobes.
- Computes `P = A·B·2^-WIDTH mod M` with one multiplier bit per enabled cycle.
- Holds the reduced result in an output register until the next `ld_r`.
- Reports completion on `done`.

## Interface
Parameters
- `WIDTH`, default 8: operand, modulus and result width in bits.

Ports
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `ena`  input  1  clock enable. Low freezes every register except for `rst`.
- `clear`  input  1  active-low clear. Low resets the accumulator, counter, A shift register and `done`; `P` is kept. Connects to the FSM `clear_mmm`.
- `ld_a`  input  1  start: load `A` and zero the accumulator and counter.
- `ld_r`  input  1  capture the reduced accumulator into `P`.
- `A`  input  WIDTH  multiplier, scanned LSB first. Must be `< M`.
- `B`  input  WIDTH  multiplicand, sampled every iteration. Must be `< M` and stable during a run.
- `M`  input  WIDTH  odd modulus, stable during a run.
- `P`  output  WIDTH  result register.
- `done`  output  1  high once WIDTH iterations have completed.

## Operation
Internal state:
- `a_sr` (WIDTH bits): copy of `A`, shifted right one bit per iteration.
- `acc` (WIDTH+2 bits): accumulator.
- `cnt` (clog2(WIDTH+1) bits): iteration counter, saturating at WIDTH.
- `P`, `done`.

Per-edge priority, highest first:
1. `rst`: `a_sr`, `acc`, `cnt`, `P` and `done` all go to 0.
2. `ena` = 0: hold everything.
3. `clear` = 0: `a_sr`, `acc`, `cnt` and `done` go to 0. `P` holds.
4. `ld_a` = 1: `a_sr <= A`, `acc <= 0`, `cnt <= 0`, `done <= 0`.
5. `cnt < WIDTH`: perform one iteration (below).
6. `cnt == WIDTH`: idle, all state holds.

One iteration, with `a = a_sr[0]`:
- `s = acc + (a ? B : 0)`
- `q = s[0]`
- `acc <= (s + (q ? M : 0)) >> 1`
- `a_sr <= a_sr >> 1`
- `cnt <= cnt + 1`
- `done <= (cnt + 1 == WIDTH)`

Result capture:
- `red = (acc >= M) ? acc - M : acc`, truncated to WIDTH bits.
- `ld_r` is evaluated under the `ena`/`rst` gating only, independent of rules 3–6: with `ena` = 1 and `ld_r` = 1, `P <= red`.
- `red` is computed from `acc` before that edge's update.

Arithmetic invariant: after any iteration `acc < 2M`. The intermediate `s + q·M < 4M` fits in WIDTH+2 bits, so there is no overflow.

Boundary cases:
- `ld_a` while a run is in progress restarts the run.
- `ld_a` and `ld_r` together: `P` captures the old `red`, and the new run starts.
- `clear` low mid-run aborts the run; `P` is unchanged.
- `rst` mid-run: all outputs are 0 on the next edge.
- Iterations beyond WIDTH are blocked by the counter saturating at WIDTH.

## Timing
- Assert `ld_a` at edge 0. Iterations run on edges 1..WIDTH. `done` is high after edge WIDTH.
- Asserting `ld_r` on cycle WIDTH+1 makes `P` valid after edge WIDTH+1.
- Total: WIDTH+2 enabled cycles from `ld_a` to valid `P`.
- Control-FSM timing: `ld_a` in its PRE state, WIDTH cycles in its run state, `ld_r` in its POST state. This lines up exactly with the above.
- Cycles with `ena` low stretch the latency one-for-one; there is no state loss.
- Reset values: `P` = 0, `done` = 0.
- No combinational path from any input to `P` or `done`; both are registered.

## Configuration
`RSA_MMM_FINAL_SUB_EN`
- Defined: `red` includes the conditional subtraction, so `P` is in `[0, M)` for any odd `M < 2^WIDTH`.
- Undefined: `red = acc[WIDTH-1:0]` with no comparator or subtractor.
  - `P` lies in `[0, 2M)` and is congruent to the true result.
  - Callers must guarantee `M < 2^(WIDTH-1)`.
  - `acc` shrinks to WIDTH+1 bits.

## Test plan
All scenarios use WIDTH = 8.
- Basic run: `A`=5, `B`=7, `M`=13; `ld_a`, 8 run cycles, `ld_r` -> `done`=1 after edge 8; `P`=1 after edge 9, with or without the macro.
- Second vector: `A`=12, `B`=12, `M`=13 -> `P`=3.
- Large modulus, macro defined: `A`=250, `B`=250, `M`=251 -> `P`=201.
- Enable and abort:
  - `ena` low for 3 cycles mid-run -> same `P`, latency +3.
  - `clear` low at iteration 4 -> `done`=0, `cnt`=0, `P` keeps its previous value.
  - `rst` high mid-run -> `P`=0, `done`=0 next edge.
- Simultaneous strobes: `ld_a` together with `ld_r` right after a completed run -> `P` gets the old result, and the new run completes normally.
- Randomised check: 1000 random odd `M`, with `A`,`B` < `M`, against a reference model.
  - With the macro: `P` < `M` and `P == A·B·2^-8 mod M`.
  - Coverage must hit `acc ≥ M` before reduction at least once.
